inst_encoder: RTL and testbench

Byte-serial instruction encoder for the 16-bit CPU. It accepts one symbolic instruction (operation, operand source, immediate, data operand) over a valid/ready request port. It packs the instruction into the 16-bit ISA word and streams the word out as bytes over a valid/ready byte port, followed by the data operand byte when the source mode needs one. It sits on the host/test-harness side and drives the CPU's byte-wide instruction input.

---
 rtl/inst_encoder.sv | 162 ++++++++++++++++
 tb/tb_inst_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Purpose : packs one symbolic instruction into the 16-bit ISA word and streams it out as bytes,
//           followed by the data operand byte for the data-lo/data-hi sources.
// Latency : first byte valid one cycle after request accept; 2 or 3 byte beats, at least one cycle each.
// Backpressure: out_valid/out_byte/out_last hold until out_ready; req_ready low while an instruction is in flight.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_op/req_src/req_imm/req_data captured on accept
//   out_valid/out_ready      byte stream handshake; out_byte, out_last qualify the beat
//   busy                     instruction in flight
//   err                      one-cycle pulse after an illegal request was consumed
//   word                     last successfully encoded 16-bit word
module inst_encoder #(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [2:0] req_src,
  input  logic [7:0] req_imm,
  input  logic [7:0] req_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       busy,
  output logic       err,
  output logic [15:0] word
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B0   = 2'd1,
    S_B1   = 2'd2,
    S_BD   = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_OUT_LO = 2'd1;
  localparam logic [1:0] OP_LOAD   = 2'd2;

  state_t      r_state;
  state_t      w_next_state;

  logic [15:0] r_word;
  logic [7:0]  r_data;
  logic        r_has_data;
  logic        r_err;

  logic        w_accept;
  logic        w_is_alu;
  logic        w_illegal;
  logic        w_has_data;
  logic [7:0]  w_lo;
  logic [15:0] w_enc;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_accept   = req_valid && req_ready;
  // load and add are the only ops that use the source field
  assign w_is_alu   = req_op[1];
  assign w_illegal  = w_is_alu && (req_src > 3'd4);
  assign w_has_data = w_is_alu && ((req_src == 3'd2) || (req_src == 3'd3));
  // data sources carry their operand in a trailing byte, so the low field is zero
  assign w_lo       = w_has_data ? 8'h00 : req_imm;

  always_comb begin
    w_enc = 16'h0000;
    case (req_op)
      OP_NOP:    w_enc = 16'h0000;
      OP_OUT_LO: w_enc = 16'h0800;
      default:   w_enc = {1'b1, 3'b000, (req_op != OP_LOAD), req_src, w_lo};
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept && !w_illegal) w_next_state = S_B0;
      S_B0:   if (out_ready) w_next_state = S_B1;
      S_B1:   if (out_ready) w_next_state = r_has_data ? S_BD : S_IDLE;
      S_BD:   if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured instruction; only legal accepts update the word
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word     <= 16'h0000;
      r_data     <= 8'h00;
      r_has_data <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_accept && !w_illegal) begin
        r_word     <= w_enc;
        r_data     <= req_data;
        r_has_data <= w_has_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from registered state only, apart from req_ready's reset gate)
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    busy      = 1'b0;
    req_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = !rst;
      end
      S_B0: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_byte  = LSB_FIRST ? r_word[7:0] : r_word[15:8];
      end
      S_B1: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_byte  = LSB_FIRST ? r_word[15:8] : r_word[7:0];
        out_last  = !r_has_data;
      end
      S_BD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_byte  = r_data;
        out_last  = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign err  = r_err;
  assign word = r_word;

endmodule

// File: tb/tb_inst_encoder.sv
// Purpose : self-checking bench for inst_encoder; drives one MSB-first and one LSB-first instance in lockstep.
// Latency : outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: out_ready randomized per cycle, with forced stalls on selected first bytes.
module tb_inst_encoder;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_op;
  logic [2:0] req_src;
  logic [7:0] req_imm;
  logic [7:0] req_data;
  logic       out_ready;

  logic        a_req_ready, a_out_valid, a_out_last, a_busy, a_err;
  logic [7:0]  a_out_byte;
  logic [15:0] a_word;
  logic        b_req_ready, b_out_valid, b_out_last, b_busy, b_err;
  logic [7:0]  b_out_byte;
  logic [15:0] b_word;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m_word;

  inst_encoder #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(a_req_ready),
    .req_op(req_op), .req_src(req_src), .req_imm(req_imm), .req_data(req_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_byte(a_out_byte), .out_last(a_out_last),
    .busy(a_busy), .err(a_err), .word(a_word)
  );

  inst_encoder #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(b_req_ready),
    .req_op(req_op), .req_src(req_src), .req_imm(req_imm), .req_data(req_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_byte(b_out_byte), .out_last(b_out_last),
    .busy(b_busy), .err(b_err), .word(b_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: encode from the instruction-set rules, then list the bytes in send order.
  task automatic model(input logic [1:0] op, input logic [2:0] src, input logic [7:0] imm,
                       input logic [7:0] data, output bit illegal, output logic [15:0] w,
                       output int n, output logic [7:0] msb_seq [3], output logic [7:0] lsb_seq [3]);
    int lo;
    int hi_part;
    bit alu;
    alu     = (op == 2) || (op == 3);
    illegal = alu && (src >= 5);
    lo      = (src == 2 || src == 3) ? 0 : int'(imm);
    if (op == 0)      hi_part = 0;
    else if (op == 1) hi_part = 'h0800;
    else if (op == 2) hi_part = 'h8000 + int'(src) * 256;
    else              hi_part = 'h8800 + int'(src) * 256;
    w = (op < 2) ? 16'(hi_part) : 16'(hi_part + lo);
    n = (alu && (src == 2 || src == 3)) ? 3 : 2;
    msb_seq[0] = 8'(int'(w) / 256);
    msb_seq[1] = 8'(int'(w) % 256);
    msb_seq[2] = data;
    lsb_seq[0] = msb_seq[1];
    lsb_seq[1] = msb_seq[0];
    lsb_seq[2] = data;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_a_valid"}, 32'(a_out_valid), 0);
    chk({tag, "_b_valid"}, 32'(b_out_valid), 0);
    chk({tag, "_a_byte"},  32'(a_out_byte), 0);
    chk({tag, "_a_last"},  32'(a_out_last), 0);
    chk({tag, "_a_busy"},  32'(a_busy), 0);
    chk({tag, "_b_busy"},  32'(b_busy), 0);
    chk({tag, "_a_rdy"},   32'(a_req_ready), 32'(!rst));
    chk({tag, "_b_rdy"},   32'(b_req_ready), 32'(!rst));
    chk({tag, "_a_word"},  32'(a_word), 32'(m_word));
    chk({tag, "_b_word"},  32'(b_word), 32'(m_word));
  endtask

  // Issue one instruction from IDLE and drain it. stall_b0 forces out_ready low on the first byte.
  task automatic run_instr(input logic [1:0] op, input logic [2:0] src, input logic [7:0] imm,
                           input logic [7:0] data, input int stall_b0);
    bit          illegal;
    logic [15:0] w;
    int          n;
    logic [7:0]  ms [3];
    logic [7:0]  ls [3];
    int          k;
    int          cyc;
    int          stall_left;
    bit          rdy;
    model(op, src, imm, data, illegal, w, n, ms, ls);

    chk("acc_a_rdy", 32'(a_req_ready), 1);
    req_valid = 1'b1;
    req_op    = op;
    req_src   = src;
    req_imm   = imm;
    req_data  = data;
    out_ready = 1'($urandom_range(0, 1));
    step();
    // scramble the request inputs: the captured instruction must not follow them
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_src   = 3'($urandom);
    req_imm   = 8'($urandom);
    req_data  = 8'($urandom);

    if (illegal) begin
      chk("ill_a_err", 32'(a_err), 1);
      chk("ill_b_err", 32'(b_err), 1);
      check_idle("ill");
      step();
      chk("ill_a_err_pulse", 32'(a_err), 0);
      chk("ill_b_err_pulse", 32'(b_err), 0);
      check_idle("ill_post");
      return;
    end

    m_word     = w;
    k          = 0;
    cyc        = 0;
    stall_left = stall_b0;
    while (k < n) begin
      if (cyc > 60) begin
        chk("timeout_bytes", 32'(k), 32'(n));
        break;
      end
      chk("fl_a_valid", 32'(a_out_valid), 1);
      chk("fl_b_valid", 32'(b_out_valid), 1);
      chk("fl_a_byte",  32'(a_out_byte), 32'(ms[k]));
      chk("fl_b_byte",  32'(b_out_byte), 32'(ls[k]));
      chk("fl_a_last",  32'(a_out_last), 32'(k == n - 1));
      chk("fl_b_last",  32'(b_out_last), 32'(k == n - 1));
      chk("fl_a_busy",  32'(a_busy), 1);
      chk("fl_a_rdy",   32'(a_req_ready), 0);
      chk("fl_b_rdy",   32'(b_req_ready), 0);
      chk("fl_a_word",  32'(a_word), 32'(m_word));
      chk("fl_b_word",  32'(b_word), 32'(m_word));
      chk("fl_a_err",   32'(a_err), 0);
      if (k == 0 && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      out_ready = rdy;
      // request activity while busy must be ignored
      req_valid = 1'($urandom);
      req_op    = 2'($urandom);
      req_src   = 3'($urandom);
      req_imm   = 8'($urandom);
      req_data  = 8'($urandom);
      step();
      if (rdy) k++;
      cyc++;
    end
    req_valid = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    check_idle("done");
  endtask

  initial begin
    logic [1:0] r_op;
    logic [2:0] r_src;

    rst       = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'd2;
    req_src   = 3'd0;
    req_imm   = 8'hA5;
    req_data  = 8'h3C;
    out_ready = 1'b1;
    m_word    = 16'h0000;

    // reset state, with a request pending that must not be taken
    repeat (3) step();
    chk("rst_a_err", 32'(a_err), 0);
    check_idle("rst");
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("post_rst_a_rdy", 32'(a_req_ready), 1);
    check_idle("post_rst");

    // directed cases
    run_instr(2'd2, 3'd0, 8'h5A, 8'h11, 0);   // load imm lo  -> 80 5A
    chk("word_805A", 32'(a_word), 32'h805A);
    run_instr(2'd3, 3'd3, 8'h77, 8'hC3, 0);   // add data hi  -> 8B 00 C3
    chk("word_8B00", 32'(a_word), 32'h8B00);
    run_instr(2'd1, 3'd7, 8'hFF, 8'h00, 0);   // out_lo, src ignored
    run_instr(2'd0, 3'd5, 8'h33, 8'h00, 0);   // nop
    run_instr(2'd2, 3'd6, 8'h99, 8'h00, 0);   // illegal source
    chk("word_after_ill", 32'(a_word), 32'h0000);
    run_instr(2'd2, 3'd4, 8'h12, 8'h00, 0);   // load ram -> 84 12
    run_instr(2'd3, 3'd1, 8'h3C, 8'h00, 4);   // add imm hi with 4-cycle stall -> 89 3C

    // reset after the first byte has transferred
    req_valid = 1'b1;
    req_op    = 2'd2;
    req_src   = 3'd0;
    req_imm   = 8'h5A;
    out_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("mid_a_byte0", 32'(a_out_byte), 32'h80);
    step();
    chk("mid_a_byte1", 32'(a_out_byte), 32'h5A);
    rst = 1'b1;
    step();
    m_word = 16'h0000;
    check_idle("mid_rst");
    rst = 1'b0;
    #1;
    run_instr(2'd0, 3'd0, 8'h00, 8'h00, 0);

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      r_op  = 2'($urandom);
      r_src = 3'($urandom);
      run_instr(r_op, r_src, 8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0) ? 3 : 0);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'($urandom);
        step();
        check_idle("gap");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
